fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the single-cycle datapath's decode/execute logic. It walks the program counter from `startpc`, requests 32-bit words from a variable-latency instruction memory, and buffers returned instructions with their PCs in a small FIFO. It presents them downstream through a valid/ready handshake. A redirect from the downstream branch logic flushes the buffer and restarts fetch at the target. Any in-flight memory response is discarded.

---
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: walks the PC, issues one-outstanding instruction memory requests and queues words with their PCs.
// Optional build macro FETCH_PERF_EN adds the stall_count output and its saturating counter.
module fetch_unit #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startpc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_count
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_LOAD    = 3'd1,
    S_REQ     = 3'd2,
    S_WAIT    = 3'd3,
    S_DISCARD = 3'd4
  } state_e;

  state_e        state_r;
  logic [63:0]   fetchpc_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   q_instr_r [DEPTH];
  logic [63:0]   q_pc_r    [DEPTH];

  logic          busy_s;
  logic          ack_s;
  logic          push_s;
  logic          pop_s;
  logic          room_s;
  logic [CW-1:0] count_nxt_s;
  logic [63:0]   redir_pc_s;
  logic [63:0]   load_pc_s;
  logic [63:0]   drain_pc_s;
  logic [63:0]   pc_inc_s;
  logic          unused_s;

  assign unused_s    = ^{startpc[1:0], redirect_pc[1:0]};
  assign redir_pc_s  = {redirect_pc[63:2], 2'b00};
  assign load_pc_s   = redirect ? redir_pc_s : {startpc[63:2], 2'b00};
  assign drain_pc_s  = redirect ? redir_pc_s : fetchpc_r;
  assign pc_inc_s    = fetchpc_r + 64'd4;
  assign busy_s      = (state_r == S_REQ) || (state_r == S_WAIT);
  assign ack_s       = imem_req & imem_ack;
  // A redirect drops the word arriving alongside it; DISCARD never pushes.
  assign push_s      = ack_s & busy_s & ~redirect;
  assign pop_s       = instr_valid & instr_ready;
  assign instr_valid = (count_r != {CW{1'b0}});
  assign instr       = q_instr_r[rd_ptr_r];
  assign instr_pc    = q_pc_r[rd_ptr_r];
  assign room_s      = (count_nxt_s < CW'(DEPTH));

  // Next queue occupancy from this cycle's push and pop.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Fetch FSM: fetch PC, registered request outputs and redirect/discard sequencing.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_r   <= S_RESET;
      fetchpc_r <= 64'd0;
      imem_req  <= 1'b0;
      imem_addr <= 64'd0;
    end else begin
      case (state_r)
        S_RESET: begin
          state_r <= S_LOAD;
        end
        S_LOAD: begin
          fetchpc_r <= load_pc_s;
          imem_addr <= load_pc_s;
          imem_req  <= 1'b1;
          state_r   <= S_REQ;
        end
        S_REQ, S_WAIT: begin
          if (redirect) begin
            fetchpc_r <= redir_pc_s;
            if (imem_req && !imem_ack) begin
              state_r <= S_DISCARD;
            end else begin
              state_r   <= S_REQ;
              imem_req  <= 1'b1;
              imem_addr <= redir_pc_s;
            end
          end else if (ack_s) begin
            fetchpc_r <= pc_inc_s;
            imem_addr <= pc_inc_s;
            imem_req  <= room_s;
            state_r   <= S_REQ;
          end else if (imem_req) begin
            state_r <= S_WAIT;
          end else begin
            imem_addr <= fetchpc_r;
            imem_req  <= room_s;
            state_r   <= S_REQ;
          end
        end
        S_DISCARD: begin
          fetchpc_r <= drain_pc_s;
          if (imem_ack) begin
            imem_addr <= drain_pc_s;
            imem_req  <= 1'b1;
            state_r   <= S_REQ;
          end else begin
            state_r <= S_DISCARD;
          end
        end
        default: begin
          state_r  <= S_RESET;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Instruction/PC queue storage, pointers and occupancy.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_r[i] <= 32'd0;
        q_pc_r[i]    <= 64'd0;
      end
    end else if (redirect && (state_r != S_RESET)) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        q_instr_r[wr_ptr_r] <= imem_rdata;
        q_pc_r[wr_ptr_r]    <= fetchpc_r;
        wr_ptr_r            <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating count of cycles where downstream was ready but nothing was offered.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      stall_count <= 32'd0;
    end else if ((state_r != S_RESET) && instr_ready && !instr_valid &&
                 (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
